// File: rtl/mult_hilo_unit_pkg.sv
// Shared constants for the HI/LO multiplier: FSM encoding, default operand width,
// and iteration counter sizing.
// Imported by the interface, the shift-add step and the top-level unit.
package mult_pkg;

    localparam int MULT_WIDTH = 32;

    // FSM encoding, kept as plain 2-bit constants for legacy tool compatibility
    localparam logic [1:0] MS_IDLE = 2'd0;
    localparam logic [1:0] MS_RUN  = 2'd1;
    localparam logic [1:0] MS_DONE = 2'd2;

    // Counter must hold 0..WIDTH-1 with headroom
    function automatic int mult_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int MULT_CNT_W = mult_cnt_width(MULT_WIDTH);

endpackage

// File: rtl/mult_hilo_unit_if.sv
// Bus between the CPU datapath and the HI/LO multiplier.
// master: CPU side (drives start/operands/mthi/mtlo, reads busy/done/hi/lo).
// slave: multiplier side.
interface mult_hilo_unit_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, a, b, wr_hi, wr_lo, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, a, b, wr_hi, wr_lo, wr_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_hilo_unit_shift_add_step.sv
// One radix-2 shift-add iteration: conditionally add multiplicand into the upper
// half of the accumulator, then shift right by one keeping the adder carry-out.
// Purely combinational; ports: i_acc, i_mcand, i_mlsb in, o_acc out.
module mult_shift_add_step
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic               i_mlsb,
    output logic [2*WIDTH-1:0] o_acc
);
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [2*WIDTH:0] w_full;

    assign w_addend = i_mlsb ? i_mcand : '0;
    // Carry-out lands in w_sum[WIDTH] and becomes the new MSB after the shift
    assign w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_full   = {w_sum, i_acc[WIDTH-1:0]};
    assign o_acc    = (2*WIDTH)'(w_full >> 1);
endmodule

// File: rtl/mult_hilo_unit.sv
// Sequential WIDTHxWIDTH mult/multu with architectural HI/LO registers (mthi/mtlo).
// Ports: clk, reset (sync, active-high), bus (slave modport: start/operands/
// mthi-mtlo writes in, busy/done/hi/lo out). Result WIDTH cycles after start.
module mult_hilo_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    mult_hilo_unit_if.slave bus
);
    localparam int CW = mult_cnt_width(WIDTH);

    logic [1:0]         r_state;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic [2*WIDTH-1:0] w_next_acc;
    logic [2*WIDTH-1:0] w_result;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_idle_like;
    logic               w_last;

    mult_shift_add_step #(.WIDTH(WIDTH)) u_step (
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .i_mlsb  (r_mplier[0]),
        .o_acc   (w_next_acc)
    );

    // Magnitudes: the most-negative value negates to itself, which is the
    // correct unsigned magnitude, so no overflow case exists.
    assign w_a_mag     = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_b_mag     = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign w_result    = r_neg ? -w_next_acc : w_next_acc;
    assign w_idle_like = (r_state != MS_RUN);
    assign w_last      = (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= MS_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            // mthi/mtlo only outside RUN; a same-edge start still proceeds and
            // its product overwrites these later.
            if (w_idle_like && bus.wr_hi) r_hi <= bus.wr_data;
            if (w_idle_like && bus.wr_lo) r_lo <= bus.wr_data;

            case (r_state)
                MS_IDLE, MS_DONE: begin
                    if (bus.start) begin
                        r_mcand  <= w_a_mag;
                        r_mplier <= w_b_mag;
                        r_neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= MS_RUN;
                    end else begin
                        r_state  <= MS_IDLE;
                    end
                end
                MS_RUN: begin
                    // start is deliberately ignored here
                    r_acc    <= w_next_acc;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (w_last) begin
                        r_hi    <= w_result[2*WIDTH-1:WIDTH];
                        r_lo    <= w_result[WIDTH-1:0];
                        r_state <= MS_DONE;
                    end
                end
                default: r_state <= MS_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state == MS_RUN);
    assign bus.done = (r_state == MS_DONE);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mult_hilo_unit.sv
module tb_mult_hilo_unit;
    import mult_pkg::*;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl[8];

    always #5 clk = ~clk;

    mult_hilo_unit_if #(.WIDTH(32)) bus();

    mult_hilo_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the DONE cycle.
    task automatic run_mul(input string nm, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi,
                           input logic [31:0] elo);
        int cyc;
        bus.start = 1'b1; bus.is_signed = sgn; bus.a = a; bus.b = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk({nm, " busy_after_start"}, 32'(bus.busy), 32'd1);
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk({nm, " busy_cycles"}, cyc, 32'd32);
        chk({nm, " done"}, 32'(bus.done), 32'd1);
        chk({nm, " hi"}, bus.hi, ehi);
        chk({nm, " lo"}, bus.lo, elo);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dcount;

        tbl[0] = '{1'b0, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
        tbl[1] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[2] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        tbl[3] = '{1'b1, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[4] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[5] = '{1'b0, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
        tbl[6] = '{1'b1, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};
        tbl[7] = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

        reset = 1'b1;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset hi", bus.hi, 32'd0);
        chk("reset lo", bus.lo, 32'd0);

        // Table vectors; each new start lands in the previous DONE cycle.
        for (int i = 0; i < 8; i++) begin
            run_mul($sformatf("vec%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b,
                    tbl[i].hi, tbl[i].lo);
        end
        @(negedge clk);
        chk("done one-cycle", 32'(bus.done), 32'd0);

        // mthi + mtlo in IDLE
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'h12345678;
        @(negedge clk);
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
        chk("mthi idle", bus.hi, 32'h12345678);
        chk("mtlo idle", bus.lo, 32'h12345678);

        // start and wr_hi during RUN are ignored
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.a = 32'd3; bus.b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd9;
        bus.wr_hi = 1'b1; bus.wr_data = 32'hDEADBEEF;
        @(negedge clk);
        bus.start = 1'b0; bus.wr_hi = 1'b0;
        chk("run hi unchanged", bus.hi, 32'h12345678);
        chk("run lo unchanged", bus.lo, 32'h12345678);
        dcount = 0;
        for (int c = 0; c < 60 && !bus.done; c++) @(negedge clk);
        chk("ignore done", 32'(bus.done), 32'd1);
        chk("ignore hi", bus.hi, 32'h00000000);
        chk("ignore lo", bus.lo, 32'h0000000F);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) dcount++;
            if (bus.busy) dcount += 100;
        end
        chk("ignore single done, no restart", dcount, 32'd0);

        // Back-to-back: start in DONE cycle accepted without an idle gap
        run_mul("b2b first", 1'b0, 32'd6, 32'd7, 32'd0, 32'd42);
        run_mul("b2b second", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6);

        // Reset at iteration 10 of a multiply
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b1; bus.a = 32'hFFFFFFF9; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre-reset busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset hi", bus.hi, 32'd0);
        chk("midreset lo", bus.lo, 32'd0);
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        chk("midreset no done", dcount, 32'd0);
        chk("midreset hi stays", bus.hi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
